// File: rtl/entrada_decimal.sv
// Decimal keypad entry: BCD digits are shifted in right-justified, then confirmar runs a
// MAX_DIGITOS-cycle Horner conversion; valor_valido pulses MAX_DIGITOS+1 edges after confirmar.
module entrada_decimal #(
   parameter int MAX_DIGITOS = 4,
   parameter int LARGURA     = 32
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [3:0]               digito_in,
   input  logic                     digito_valido,
   input  logic                     apagar,
   input  logic                     confirmar,
   output logic [LARGURA-1:0]       valor_out,
   output logic                     valor_valido,
   output logic [4*MAX_DIGITOS-1:0] digitos_out,
   output logic [3:0]               contagem,
   output logic                     ocupado,
   output logic                     erro
);

   localparam int IDX_W = (MAX_DIGITOS > 1) ? $clog2(MAX_DIGITOS) : 1;
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAX_DIGITOS - 1);
   localparam logic [3:0]       CNT_MAX = 4'(MAX_DIGITOS);

   typedef enum logic [1:0] {
      COLETA   = 2'd0,
      CONVERTE = 2'd1,
      PRONTO   = 2'd2
   } estado_t;

   estado_t                  estado_q,   estado_d;
   logic [4*MAX_DIGITOS-1:0] digitos_q,  digitos_d;
   logic [3:0]               contagem_q, contagem_d;
   logic [LARGURA-1:0]       acc_q,      acc_d;
   logic [IDX_W-1:0]         idx_q,      idx_d;
   logic [LARGURA-1:0]       valor_q,    valor_d;
   logic                     valido_q,   valido_d;
   logic                     erro_q,     erro_d;

   logic [3:0]               nibble;
   logic [LARGURA-1:0]       nibble_ext;
   logic [4*MAX_DIGITOS-1:0] digito_ext;
   logic                     digito_aceito;

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q   <= COLETA;
         digitos_q  <= '0;
         contagem_q <= '0;
         acc_q      <= '0;
         idx_q      <= '0;
         valor_q    <= '0;
         valido_q   <= 1'b0;
         erro_q     <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         digitos_q  <= digitos_d;
         contagem_q <= contagem_d;
         acc_q      <= acc_d;
         idx_q      <= idx_d;
         valor_q    <= valor_d;
         valido_q   <= valido_d;
         erro_q     <= erro_d;
      end
   end

   // Next-state logic
   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         COLETA:   if (!apagar && confirmar) estado_d = CONVERTE;
         CONVERTE: if (idx_q == '0)          estado_d = PRONTO;
         PRONTO:                             estado_d = COLETA;
         default:                            estado_d = COLETA;
      endcase
   end

   // Datapath and registered-output logic
   always_comb begin
      nibble         = 4'(digitos_q >> {idx_q, 2'b00});
      nibble_ext     = '0;
      nibble_ext[3:0] = nibble;
      digito_ext     = '0;
      digito_ext[3:0] = digito_in;
      digito_aceito  = (digito_in <= 4'd9) && (contagem_q < CNT_MAX);

      digitos_d  = digitos_q;
      contagem_d = contagem_q;
      acc_d      = acc_q;
      idx_d      = idx_q;
      valor_d    = valor_q;
      valido_d   = 1'b0;
      erro_d     = 1'b0;

      case (estado_q)
         COLETA: begin
            if (apagar) begin
               digitos_d  = '0;
               contagem_d = '0;
            end else if (confirmar) begin
               acc_d = '0;
               idx_d = IDX_MAX;
            end else if (digito_valido) begin
               if (digito_aceito) begin
                  digitos_d  = (digitos_q << 4) | digito_ext;
                  contagem_d = contagem_q + 4'd1;
               end else begin
                  erro_d = 1'b1;
               end
            end
         end
         CONVERTE: begin
            // acc*10 as shift-add; wraps idx on the final step, which is never used
            acc_d = (acc_q << 3) + (acc_q << 1) + nibble_ext;
            idx_d = idx_q - IDX_W'(1);
         end
         PRONTO: begin
            valor_d    = acc_q;
            valido_d   = 1'b1;
            digitos_d  = '0;
            contagem_d = '0;
         end
         default: ;
      endcase
   end

   // Output logic
   always_comb begin
      valor_out    = valor_q;
      valor_valido = valido_q;
      digitos_out  = digitos_q;
      contagem     = contagem_q;
      ocupado      = (estado_q != COLETA);
      erro         = erro_q;
   end

endmodule

// File: tb/tb_entrada_decimal.sv
// Bench for entrada_decimal: table-driven entries plus hand-written corner sequences,
// with converted values checked through a queue scoreboard on every valor_valido pulse.
module tb_entrada_decimal;

   localparam int MAXD = 4;
   localparam int LARG = 32;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [3:0]      digito_in = '0;
   logic            digito_valido = 1'b0;
   logic            apagar = 1'b0;
   logic            confirmar = 1'b0;
   logic [LARG-1:0] valor_out;
   logic            valor_valido;
   logic [4*MAXD-1:0] digitos_out;
   logic [3:0]      contagem;
   logic            ocupado;
   logic            erro;

   int total = 0;
   int bad   = 0;
   int erro_cnt = 0;
   logic [31:0] exp_q[$];

   entrada_decimal #(.MAX_DIGITOS(MAXD), .LARGURA(LARG)) dut (
      .clock(clock), .reset(reset), .digito_in(digito_in), .digito_valido(digito_valido),
      .apagar(apagar), .confirmar(confirmar), .valor_out(valor_out),
      .valor_valido(valor_valido), .digitos_out(digitos_out), .contagem(contagem),
      .ocupado(ocupado), .erro(erro)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   // Scoreboard: every valor_valido pulse must match the oldest pending expectation
   always @(negedge clock) begin
      if (erro === 1'b1) erro_cnt++;
      if (valor_valido === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid: got valor_out=%0d with nothing pending", valor_out);
         end else begin
            chk("scoreboard_valor", 64'(valor_out), 64'(exp_q.pop_front()));
         end
      end
   end

   task automatic poke(input logic dv, input logic [3:0] d, input logic ap, input logic cf);
      digito_valido = dv;
      digito_in     = d;
      apagar        = ap;
      confirmar     = cf;
      @(posedge clock);
      #1;
      digito_valido = 1'b0;
      digito_in     = '0;
      apagar        = 1'b0;
      confirmar     = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) poke(1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   // Called right after the confirmar edge; checks latency and the PRONTO cleanup
   task automatic wait_done(input string nm, input logic [31:0] expv);
      int k;
      chk({nm, "_ocupado_hi"}, 64'(ocupado), 64'd1);
      k = 0;
      do begin
         @(posedge clock);
         #1;
         k++;
      end while (valor_valido !== 1'b1 && k < 20);
      chk({nm, "_latency"}, 64'(k), 64'(MAXD + 1));
      chk({nm, "_valor"}, 64'(valor_out), 64'(expv));
      chk({nm, "_ocupado_lo"}, 64'(ocupado), 64'd0);
      chk({nm, "_contagem0"}, 64'(contagem), 64'd0);
      chk({nm, "_digitos0"}, 64'(digitos_out), 64'd0);
      @(posedge clock);
      #1;
      chk({nm, "_pulse_1cyc"}, 64'(valor_valido), 64'd0);
   endtask

   typedef struct {
      string       nm;
      int          n;
      logic [31:0] digs;
      logic [15:0] exp_bcd;
      logic [3:0]  exp_cnt;
      logic [31:0] exp_val;
      int          exp_err;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int e0;
      vecs[0] = '{"v42",    2, 32'h00024, 16'h0042, 4'd2, 32'd42,   0};
      vecs[1] = '{"v9999",  5, 32'h79999, 16'h9999, 4'd4, 32'd9999, 1};
      vecs[2] = '{"vempty", 0, 32'h00000, 16'h0000, 4'd0, 32'd0,    0};
      vecs[3] = '{"vbadF",  3, 32'h002F1, 16'h0012, 4'd2, 32'd12,   1};
      vecs[4] = '{"v0007",  4, 32'h07000, 16'h0007, 4'd4, 32'd7,    0};
      vecs[5] = '{"v9001",  4, 32'h01009, 16'h9001, 4'd4, 32'd9001, 0};
      vecs[6] = '{"v8",     1, 32'h00008, 16'h0008, 4'd1, 32'd8,    0};

      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      chk("rst_valor", 64'(valor_out), 64'd0);
      chk("rst_valido", 64'(valor_valido), 64'd0);
      chk("rst_digitos", 64'(digitos_out), 64'd0);
      chk("rst_contagem", 64'(contagem), 64'd0);
      chk("rst_ocupado", 64'(ocupado), 64'd0);
      chk("rst_erro", 64'(erro), 64'd0);

      for (int v = 0; v < 7; v++) begin
         e0 = erro_cnt;
         for (int i = 0; i < vecs[v].n; i++) poke(1'b1, vecs[v].digs[i*4 +: 4], 1'b0, 1'b0);
         idle(1);
         chk({vecs[v].nm, "_bcd"}, 64'(digitos_out), 64'(vecs[v].exp_bcd));
         chk({vecs[v].nm, "_cnt"}, 64'(contagem), 64'(vecs[v].exp_cnt));
         chk({vecs[v].nm, "_erro"}, 64'(erro_cnt - e0), 64'(vecs[v].exp_err));
         exp_q.push_back(vecs[v].exp_val);
         poke(1'b0, 4'd0, 1'b0, 1'b1);
         wait_done(vecs[v].nm, vecs[v].exp_val);
      end

      // Bad digit, then apagar, then re-entry
      e0 = erro_cnt;
      poke(1'b1, 4'hA, 1'b0, 1'b0);
      poke(1'b1, 4'h3, 1'b0, 1'b0);
      poke(1'b0, 4'd0, 1'b1, 1'b0);
      chk("apagar_cnt", 64'(contagem), 64'd0);
      chk("apagar_bcd", 64'(digitos_out), 64'd0);
      chk("apagar_erro", 64'(erro_cnt - e0), 64'd1);
      poke(1'b1, 4'h1, 1'b0, 1'b0);
      poke(1'b1, 4'h0, 1'b0, 1'b0);
      exp_q.push_back(32'd10);
      poke(1'b0, 4'd0, 1'b0, 1'b1);
      wait_done("v10", 32'd10);

      // Reset during the second conversion cycle aborts with no pulse
      for (int i = 1; i <= 4; i++) poke(1'b1, 4'(i), 1'b0, 1'b0);
      poke(1'b0, 4'd0, 1'b0, 1'b1);
      idle(1);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      chk("abort_valor", 64'(valor_out), 64'd0);
      chk("abort_ocupado", 64'(ocupado), 64'd0);
      chk("abort_bcd", 64'(digitos_out), 64'd0);
      chk("abort_cnt", 64'(contagem), 64'd0);
      idle(8);
      poke(1'b1, 4'h5, 1'b0, 1'b0);
      exp_q.push_back(32'd5);
      poke(1'b0, 4'd0, 1'b0, 1'b1);
      wait_done("v5", 32'd5);

      // Digit together with confirmar is dropped silently
      e0 = erro_cnt;
      poke(1'b1, 4'h1, 1'b0, 1'b0);
      poke(1'b1, 4'h2, 1'b0, 1'b0);
      exp_q.push_back(32'd12);
      poke(1'b1, 4'h7, 1'b0, 1'b1);
      wait_done("dig_conf", 32'd12);
      chk("dig_conf_erro", 64'(erro_cnt - e0), 64'd0);

      // apagar together with confirmar clears and never converts
      poke(1'b1, 4'h3, 1'b0, 1'b0);
      poke(1'b0, 4'd0, 1'b1, 1'b1);
      chk("ap_conf_ocupado", 64'(ocupado), 64'd0);
      chk("ap_conf_cnt", 64'(contagem), 64'd0);
      idle(8);

      // Held digito_valido accepts one digit per cycle
      digito_valido = 1'b1;
      digito_in = 4'h3;
      repeat (3) @(posedge clock);
      #1;
      digito_valido = 1'b0;
      chk("held_dig_bcd", 64'(digitos_out), 64'h0333);
      chk("held_dig_cnt", 64'(contagem), 64'd3);
      poke(1'b0, 4'd0, 1'b1, 1'b0);

      // Held confirmar: converts the entry, then the empty entry again
      poke(1'b1, 4'h6, 1'b0, 1'b0);
      exp_q.push_back(32'd6);
      exp_q.push_back(32'd0);
      confirmar = 1'b1;
      repeat (MAXD + 3) @(posedge clock);
      #1;
      confirmar = 1'b0;
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(posedge clock);
      idle(3);
      chk("held_conf_pending", 64'(exp_q.size()), 64'd0);
      chk("held_conf_last", 64'(valor_out), 64'd0);

      idle(4);
      chk("final_pending", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
